// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a program image into port B from a UART byte stream.
// The stream is a 4-byte little-endian word count N, then N little-endian words.
// Each complete word is written one cycle after its last byte arrives. uart_done
// then hands port B and the core back to normal operation.
// Ports:
//   cpuclk, rst_n          clock, async active-low reset
//   rx_valid, rx_byte      received byte strobe and data
//   load_start             restart: wait for a new header
//   skip                   finish without loading (only before any header byte)
//   uart_addr/data/we      port-B write bus
//   uart_done, load_err    load finished / load aborted
//   word_cnt               words written in this load
module uart_boot_loader #(
    parameter logic [31:0]  BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned  MAX_WORDS   = 16384,
    parameter int unsigned  TIMEOUT_CYC = 50_000_000,
    localparam int unsigned CW          = $clog2(MAX_WORDS + 1)
) (
    input  logic          cpuclk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_byte,
    input  logic          load_start,
    input  logic          skip,
    output logic [31:0]   uart_addr,
    output logic [31:0]   uart_data,
    output logic          uart_we,
    output logic          uart_done,
    output logic          load_err,
    output logic [CW-1:0] word_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {HDR, LOAD, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   asm_q, asm_d;            // low three bytes of the word in progress
    logic [CW-1:0] n_q, n_d;                // header word count
    logic [CW-1:0] rcvd_q, rcvd_d;          // words fully assembled
    logic          pend_q, pend_d;          // assembled word waiting for its strobe
    logic [31:0]   pend_word_q, pend_word_d;
    logic          pend_last_q, pend_last_d;
    logic          fin_q, fin_d;            // last strobe issued, raise done next
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   addr_d, data_d;
    logic          we_d, done_d, err_d;
    logic [CW-1:0] word_cnt_d;

    logic [31:0]   full_word;
    logic          timeout;

    assign full_word = {rx_byte, asm_q};
    assign timeout   = (timer_q == TW'(TIMEOUT_CYC - 1));

    // Next-state and output computation
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        n_d         = n_q;
        rcvd_d      = rcvd_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        pend_last_d = pend_last_q;
        fin_d       = fin_q;
        timer_d     = timer_q;
        addr_d      = uart_addr;
        data_d      = uart_data;
        we_d        = 1'b0;
        done_d      = uart_done;
        err_d       = load_err;
        word_cnt_d  = word_cnt;

        if (load_start) begin
            state_d    = HDR;
            byte_idx_d = 2'd0;
            timer_d    = '0;
            word_cnt_d = '0;
            rcvd_d     = '0;
            pend_d     = 1'b0;
            fin_d      = 1'b0;
            addr_d     = BASE_ADDR;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            // Shared byte assembly for the first three bytes of any word
            if (rx_valid && byte_idx_q != 2'd3) begin
                case (byte_idx_q)
                    2'd0:    asm_d[7:0]   = rx_byte;
                    2'd1:    asm_d[15:8]  = rx_byte;
                    default: asm_d[23:16] = rx_byte;
                endcase
            end
            case (state_q)
                HDR: begin
                    if (byte_idx_q == 2'd0 && skip) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (rx_valid) begin
                        timer_d    = '0;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            if (full_word == 32'd0) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else if (full_word > 32'(MAX_WORDS)) begin
                                state_d = ERR;
                                err_d   = 1'b1;
                            end else begin
                                state_d    = LOAD;
                                n_d        = CW'(full_word);
                                rcvd_d     = '0;
                                word_cnt_d = '0;
                            end
                        end
                    end else if (byte_idx_q != 2'd0) begin
                        timer_d = timer_q + TW'(1);
                        if (timeout) begin
                            state_d    = ERR;
                            err_d      = 1'b1;
                            byte_idx_d = 2'd0;
                        end
                    end
                end
                LOAD: begin
                    if (pend_q) begin
                        we_d       = 1'b1;
                        data_d     = pend_word_q;
                        addr_d     = BASE_ADDR + (32'(word_cnt) << 2);
                        word_cnt_d = word_cnt + CW'(1);
                        pend_d     = 1'b0;
                        fin_d      = pend_last_q;
                    end
                    if (fin_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fin_d   = 1'b0;
                    end else if (rcvd_q != n_q) begin
                        if (rx_valid) begin
                            timer_d    = '0;
                            byte_idx_d = byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd3) begin
                                pend_d      = 1'b1;
                                pend_word_d = full_word;
                                pend_last_d = (rcvd_q == n_q - CW'(1));
                                rcvd_d      = rcvd_q + CW'(1);
                            end
                        end else begin
                            timer_d = timer_q + TW'(1);
                            if (timeout) begin
                                state_d    = ERR;
                                err_d      = 1'b1;
                                byte_idx_d = 2'd0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge cpuclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HDR;
            byte_idx_q  <= 2'd0;
            asm_q       <= '0;
            n_q         <= '0;
            rcvd_q      <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            pend_last_q <= 1'b0;
            fin_q       <= 1'b0;
            timer_q     <= '0;
            uart_addr   <= BASE_ADDR;
            uart_data   <= '0;
            uart_we     <= 1'b0;
            uart_done   <= 1'b0;
            load_err    <= 1'b0;
            word_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            n_q         <= n_d;
            rcvd_q      <= rcvd_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            pend_last_q <= pend_last_d;
            fin_q       <= fin_d;
            timer_q     <= timer_d;
            uart_addr   <= addr_d;
            uart_data   <= data_d;
            uart_we     <= we_d;
            uart_done   <= done_d;
            load_err    <= err_d;
            word_cnt    <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: expected port-B writes are queued
// as stimulus is driven and popped by a monitor whenever uart_we strobes.
module tb_uart_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int unsigned MAXW = 4;
    localparam int unsigned TMO  = 100;

    logic        cpuclk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        load_start;
    logic        skip;
    logic [31:0] uart_addr;
    logic [31:0] uart_data;
    logic        uart_we;
    logic        uart_done;
    logic        load_err;
    logic [2:0]  word_cnt;

    int tests  = 0;
    int fails  = 0;
    int strobes = 0;
    logic [63:0] exp_q[$];

    uart_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYC(TMO)) dut (
        .cpuclk(cpuclk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .load_start(load_start), .skip(skip), .uart_addr(uart_addr),
        .uart_data(uart_data), .uart_we(uart_we), .uart_done(uart_done),
        .load_err(load_err), .word_cnt(word_cnt)
    );

    always #5 cpuclk = ~cpuclk;

    // Scoreboard monitor: every strobe must match the oldest queued write
    always @(negedge cpuclk) begin
        if (rst_n === 1'b1 && uart_we === 1'b1) begin
            logic [63:0] e;
            strobes++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: got addr=%h data=%h, required no write", uart_addr, uart_data);
            end else begin
                e = exp_q.pop_front();
                if ({uart_addr, uart_data} !== e) begin
                    fails++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             uart_addr, uart_data, e[63:32], e[31:0]);
                end
            end
            if (uart_done !== 1'b0) begin
                fails++;
                $display("FAIL we_with_done: got done=%b during strobe, required 0", uart_done);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge cpuclk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge cpuclk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge cpuclk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0], gap);
        end
    endtask

    task automatic pulse_load_start();
        @(negedge cpuclk);
        load_start = 1'b1;
        @(negedge cpuclk);
        load_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && uart_done !== 1'b1; i++) @(negedge cpuclk);
        tests++;
        if (uart_done !== 1'b1) begin
            fails++;
            $display("FAIL %s_done_timeout: got done=%b, required 1", name, uart_done);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({uart_addr, uart_data, uart_we, uart_done, load_err, word_cnt} !==
            {BASE, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL reset: got addr=%h data=%h we=%b done=%b err=%b cnt=%0d, required %h 0 0 0 0 0",
                     uart_addr, uart_data, uart_we, uart_done, load_err, word_cnt, BASE);
        end
    endtask

    task automatic test_two_word_load();
        exp_q.push_back({BASE, 32'h1234_5678});
        exp_q.push_back({BASE + 32'd4, 32'hDEAD_BEEF});
        send_word(32'd2, 2);
        send_word(32'h1234_5678, 2);
        send_byte(8'hEF, 1);
        send_byte(8'hBE, 1);
        send_byte(8'hAD, 1);
        // Last byte sampled at edge t; just after t no strobe yet
        send_byte(8'hDE, 0);
        tests++;
        if (uart_we !== 1'b0) begin
            fails++;
            $display("FAIL t1_we_early: got we=%b after last byte edge, required 0", uart_we);
        end
        @(negedge cpuclk);
        tests++;
        if (uart_we !== 1'b1 || uart_done !== 1'b0) begin
            fails++;
            $display("FAIL t1_strobe_timing: got we=%b done=%b at t+1, required we=1 done=0", uart_we, uart_done);
        end
        @(negedge cpuclk);
        tests++;
        if (uart_we !== 1'b0 || uart_done !== 1'b1 || word_cnt !== 3'd2) begin
            fails++;
            $display("FAIL t1_done: got we=%b done=%b cnt=%0d at t+2, required we=0 done=1 cnt=2",
                     uart_we, uart_done, word_cnt);
        end
        repeat (3) @(negedge cpuclk);
        tests++;
        if (uart_addr !== BASE + 32'd4 || uart_data !== 32'hDEAD_BEEF || uart_done !== 1'b1) begin
            fails++;
            $display("FAIL t1_hold: got addr=%h data=%h done=%b, required %h deadbeef 1",
                     uart_addr, uart_data, uart_done, BASE + 32'd4);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [12];
        int s0;
        bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pulse_load_start();
        tests++;
        if (uart_done !== 1'b0 || word_cnt !== 3'd0 || uart_addr !== BASE) begin
            fails++;
            $display("FAIL t2_restart: got done=%b cnt=%0d addr=%h, required 0 0 %h", uart_done, word_cnt, uart_addr, BASE);
        end
        s0 = strobes;
        exp_q.push_back({BASE, 32'h1234_5678});
        exp_q.push_back({BASE + 32'd4, 32'hDEAD_BEEF});
        for (int i = 0; i < 12; i++) begin
            @(negedge cpuclk);
            rx_valid = 1'b1;
            rx_byte  = bytes[i];
        end
        @(negedge cpuclk);
        rx_valid = 1'b0;
        wait_done("t2");
        repeat (2) @(negedge cpuclk);
        tests++;
        if (strobes - s0 != 2 || exp_q.size() != 0 || word_cnt !== 3'd2) begin
            fails++;
            $display("FAIL t2_count: got strobes=%0d pending=%0d cnt=%0d, required 2 0 2",
                     strobes - s0, exp_q.size(), word_cnt);
        end
    endtask

    task automatic test_zero_and_skip();
        pulse_load_start();
        send_word(32'd0, 0);
        tests++;
        if (uart_done !== 1'b1 || word_cnt !== 3'd0) begin
            fails++;
            $display("FAIL t3_zero_hdr: got done=%b cnt=%0d, required 1 0", uart_done, word_cnt);
        end
        // skip straight after reset
        @(negedge cpuclk);
        rst_n = 1'b0;
        @(negedge cpuclk);
        rst_n = 1'b1;
        skip  = 1'b1;
        @(negedge cpuclk);
        skip = 1'b0;
        tests++;
        if (uart_done !== 1'b1) begin
            fails++;
            $display("FAIL t3_skip: got done=%b next cycle, required 1", uart_done);
        end
        // skip after one header byte is ignored
        pulse_load_start();
        send_byte(8'h01, 0);
        skip = 1'b1;
        repeat (4) @(negedge cpuclk);
        skip = 1'b0;
        tests++;
        if (uart_done !== 1'b0) begin
            fails++;
            $display("FAIL t3_skip_ignored: got done=%b, required 0", uart_done);
        end
    endtask

    task automatic test_oversize();
        pulse_load_start();
        send_word(32'd5, 1);
        tests++;
        if (load_err !== 1'b1 || uart_done !== 1'b0) begin
            fails++;
            $display("FAIL t4_oversize: got err=%b done=%b, required 1 0", load_err, uart_done);
        end
        pulse_load_start();
        tests++;
        if (load_err !== 1'b0) begin
            fails++;
            $display("FAIL t4_err_clear: got err=%b after load_start, required 0", load_err);
        end
        exp_q.push_back({BASE, 32'hDDCC_BBAA});
        send_word(32'd1, 0);
        send_word(32'hDDCC_BBAA, 0);
        wait_done("t4");
        tests++;
        if (load_err !== 1'b0 || word_cnt !== 3'd1) begin
            fails++;
            $display("FAIL t4_reload: got err=%b cnt=%0d, required 0 1", load_err, word_cnt);
        end
    endtask

    task automatic test_timeout();
        int s0;
        pulse_load_start();
        s0 = strobes;
        send_word(32'd1, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (TMO - 1) @(negedge cpuclk);
        tests++;
        if (load_err !== 1'b0) begin
            fails++;
            $display("FAIL t5_early_err: got err=%b at 99 cycles, required 0", load_err);
        end
        @(negedge cpuclk);
        tests++;
        if (load_err !== 1'b1 || uart_done !== 1'b0 || strobes != s0 || word_cnt !== 3'd0) begin
            fails++;
            $display("FAIL t5_timeout: got err=%b done=%b strobes=%0d cnt=%0d, required 1 0 0 0",
                     load_err, uart_done, strobes - s0, word_cnt);
        end
    endtask

    task automatic test_abort();
        pulse_load_start();
        send_word(32'd1, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({uart_addr, uart_data, uart_we, uart_done, load_err, word_cnt} !==
            {BASE, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL t6_async_reset: got addr=%h data=%h we=%b done=%b err=%b cnt=%0d, required reset values",
                     uart_addr, uart_data, uart_we, uart_done, load_err, word_cnt);
        end
        @(negedge cpuclk);
        rst_n = 1'b1;
        // load_start together with the completing byte drops that byte
        send_word(32'd1, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        @(negedge cpuclk);
        rx_valid   = 1'b1;
        rx_byte    = 8'h04;
        load_start = 1'b1;
        @(negedge cpuclk);
        rx_valid   = 1'b0;
        load_start = 1'b0;
        repeat (3) @(negedge cpuclk);
        tests++;
        if (uart_we !== 1'b0 || uart_done !== 1'b0 || word_cnt !== 3'd0 || uart_addr !== BASE) begin
            fails++;
            $display("FAIL t6_ls_beats_write: got we=%b done=%b cnt=%0d addr=%h, required 0 0 0 %h",
                     uart_we, uart_done, word_cnt, uart_addr, BASE);
        end
        // Back in HDR: a fresh one-word load succeeds
        exp_q.push_back({BASE, 32'hCAFE_F00D});
        send_word(32'd1, 0);
        send_word(32'hCAFE_F00D, 0);
        wait_done("t6");
        tests++;
        if (word_cnt !== 3'd1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL t6_after_abort: got cnt=%0d pending=%0d, required 1 0", word_cnt, exp_q.size());
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_byte    = 8'h00;
        load_start = 1'b0;
        skip       = 1'b0;
        repeat (3) @(negedge cpuclk);
        test_reset();
        rst_n = 1'b1;
        @(negedge cpuclk);
        test_reset();
        test_two_word_load();
        test_back_to_back();
        test_zero_and_skip();
        test_oversize();
        test_timeout();
        test_abort();
        repeat (3) @(negedge cpuclk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_writes: got %0d unissued, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
